// File: rtl/gpio_apb_pkg.sv
// Shared definitions for the APB GPIO bank: register offsets, FSM state type
// and the default identification constant.
package gpio_apb_pkg;

    localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
    localparam logic [2:0] ADDR_DIR        = 3'd1;
    localparam logic [2:0] ADDR_DATA_IN    = 3'd2;
    localparam logic [2:0] ADDR_OUT_SET    = 3'd3;
    localparam logic [2:0] ADDR_OUT_CLR    = 3'd4;
    localparam logic [2:0] ADDR_IRQ_EN     = 3'd5;
    localparam logic [2:0] ADDR_IRQ_STATUS = 3'd6;
    localparam logic [2:0] ADDR_ID         = 3'd7;

    localparam logic [7:0] DEFAULT_BANK_ID = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/gpio_in_sync.sv
// Pin input conditioning: two-flop synchroniser, previous-value flop and
// per-pin rising-edge detect.
module gpio_in_sync #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sclk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] i_pins,
    output logic [DATA_WIDTH-1:0] o_sync,
    output logic [DATA_WIDTH-1:0] o_rise
);

    logic [DATA_WIDTH-1:0] r_meta;
    logic [DATA_WIDTH-1:0] r_sync;
    logic [DATA_WIDTH-1:0] r_prev;

    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_pins;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/apb_gpio_bank.sv
// APB responder for one GPIO bank: register file, pin output/enable drive,
// synchronised inputs and a level interrupt on enabled rising edges.
module apb_gpio_bank
    import gpio_apb_pkg::*;
#(
    parameter int               DATA_WIDTH  = 8,
    parameter int               ADDR_WIDTH  = 7,
    parameter int               WAIT_STATES = 0,
    parameter logic [7:0]       BANK_ID     = DEFAULT_BANK_ID
) (
    input  logic                  sclk,
    input  logic                  resetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic [DATA_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam logic [2:0]            WS     = 3'(WAIT_STATES);
    localparam logic [DATA_WIDTH-1:0] ID_VAL = DATA_WIDTH'(BANK_ID);

    apb_state_t            r_state;
    apb_state_t            w_phase;
    logic [2:0]            r_cnt;
    logic                  r_done;
    logic                  w_pready;
    logic                  w_hit;
    logic                  w_wr;
    logic [2:0]            w_idx;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] w_w1c;

    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] r_oe;
    logic [DATA_WIDTH-1:0] r_irq_en;
    logic [DATA_WIDTH-1:0] r_irq_st;
    logic [DATA_WIDTH-1:0] w_sync;
    logic [DATA_WIDTH-1:0] w_rise;

    gpio_in_sync #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_in_sync (
        .sclk   (sclk),
        .resetn (resetn),
        .i_pins (gpio_in),
        .o_sync (w_sync),
        .o_rise (w_rise)
    );

    // r_state holds the phase of the previous bus cycle; w_phase classifies the
    // current one so pready can rise in the very first ACCESS cycle.
    always_comb begin
        w_phase = ST_IDLE;
        case (r_state)
            ST_SETUP: begin
                if (!psel)        w_phase = ST_IDLE;
                else if (penable) w_phase = ST_ACCESS;
                else              w_phase = ST_SETUP;
            end
            ST_ACCESS: begin
                if (!psel)         w_phase = ST_IDLE;
                else if (!penable) w_phase = ST_SETUP;
                else if (r_done)   w_phase = ST_IDLE;
                else               w_phase = ST_ACCESS;
            end
            default: begin
                if (psel && !penable) w_phase = ST_SETUP;
                else                  w_phase = ST_IDLE;
            end
        endcase
    end

    assign w_pready = (w_phase == ST_ACCESS) && (r_cnt == WS);

    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_phase;
            r_done  <= w_pready;
            if (w_phase == ST_ACCESS && !w_pready) r_cnt <= r_cnt + 3'd1;
            else                                   r_cnt <= '0;
        end
    end

    assign w_hit = (paddr[ADDR_WIDTH-1:3] == '0);
    assign w_idx = paddr[2:0];
    assign w_wr  = w_pready && pwrite && w_hit;
    assign w_w1c = (w_wr && w_idx == ADDR_IRQ_STATUS) ? pwdata : '0;

    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            r_out    <= '0;
            r_oe     <= '0;
            r_irq_en <= '0;
        end else if (w_wr) begin
            case (w_idx)
                ADDR_DATA_OUT: r_out    <= pwdata;
                ADDR_DIR:      r_oe     <= pwdata;
                ADDR_OUT_SET:  r_out    <= r_out | pwdata;
                ADDR_OUT_CLR:  r_out    <= r_out & ~pwdata;
                ADDR_IRQ_EN:   r_irq_en <= pwdata;
                default:       ;
            endcase
        end
    end

    // A new rising edge overrides a same-cycle W1C on that bit.
    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) r_irq_st <= '0;
        else         r_irq_st <= (r_irq_st & ~w_w1c) | w_rise;
    end

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            ADDR_DATA_OUT:   w_rdata = r_out;
            ADDR_DIR:        w_rdata = r_oe;
            ADDR_DATA_IN:    w_rdata = w_sync;
            ADDR_IRQ_EN:     w_rdata = r_irq_en;
            ADDR_IRQ_STATUS: w_rdata = r_irq_st;
            ADDR_ID:         w_rdata = ID_VAL;
            default:         w_rdata = '0;
        endcase
    end

    assign prdata   = (w_pready && w_hit) ? w_rdata : '0;
    assign pready   = w_pready;
    assign gpio_out = r_out;
    assign gpio_oe  = r_oe;
    assign irq      = |(r_irq_st & r_irq_en);

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Bench for apb_gpio_bank: two banks (0 and 3 wait states) on a shared clock,
// read data checked through per-bank expected-value queues.
module tb_apb_gpio_bank;
    import gpio_apb_pkg::*;

    logic            sclk;
    logic            resetn;
    logic [1:0]      psel, penable, pwrite, pready, irq;
    logic [1:0][6:0] paddr;
    logic [1:0][7:0] pwdata, prdata, gpio_in, gpio_out, gpio_oe;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] e0, e1;

    apb_gpio_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .WAIT_STATES(0), .BANK_ID(8'hA5)) u_dut0 (
        .sclk(sclk), .resetn(resetn), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
        .gpio_in(gpio_in[0]), .gpio_out(gpio_out[0]), .gpio_oe(gpio_oe[0]), .irq(irq[0])
    );

    apb_gpio_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .WAIT_STATES(3), .BANK_ID(8'hA5)) u_dut1 (
        .sclk(sclk), .resetn(resetn), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
        .gpio_in(gpio_in[1]), .gpio_out(gpio_out[1]), .gpio_oe(gpio_oe[1]), .irq(irq[1])
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    // Read-completion monitors: pop the expected value when a read finishes.
    initial forever begin
        @(negedge sclk);
        if (psel[0] && penable[0] && pready[0] && !pwrite[0]) begin
            n_checks++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL rd0_unexpected: got %h expected no read", prdata[0]);
            end else begin
                e0 = q0.pop_front();
                if (prdata[0] !== e0) begin
                    n_fail++;
                    $display("FAIL rd0 addr %h: got %h expected %h", paddr[0], prdata[0], e0);
                end
            end
        end
    end

    initial forever begin
        @(negedge sclk);
        if (psel[1] && penable[1] && pready[1] && !pwrite[1]) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL rd1_unexpected: got %h expected no read", prdata[1]);
            end else begin
                e1 = q1.pop_front();
                if (prdata[1] !== e1) begin
                    n_fail++;
                    $display("FAIL rd1 addr %h: got %h expected %h", paddr[1], prdata[1], e1);
                end
            end
        end
    end

    task automatic xfer(input int d, input logic wr, input logic [6:0] addr,
                        input logic [7:0] data, input logic [7:0] exp_rd, output int waits);
        bit done = 0;
        waits = 0;
        if (!wr) begin
            if (d == 0) q0.push_back(exp_rd);
            else        q1.push_back(exp_rd);
        end
        @(posedge sclk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
        @(posedge sclk); #1;
        penable[d] = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge sclk);
            if (pready[d]) done = 1;
            else begin
                waits++;
                @(posedge sclk); #1;
            end
        end
        @(posedge sclk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; gpio_in = '0;
        repeat (3) @(posedge sclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({pready[d], irq[d], prdata[d], gpio_out[d], gpio_oe[d]} !== 25'd0) begin
                n_fail++;
                $display("FAIL reset_outputs%0d: got %h expected 0", d,
                         {pready[d], irq[d], prdata[d], gpio_out[d], gpio_oe[d]});
            end
        end
        resetn = 1'b1;
        begin
            int w;
            xfer(0, 1'b0, 7'd6, 8'h00, 8'h00, w);
            xfer(1, 1'b0, 7'd5, 8'h00, 8'h00, w);
        end
    endtask

    task automatic test_dir_data();
        int w;
        xfer(0, 1'b1, 7'd1, 8'hF0, 8'h00, w);
        n_checks++;
        if (w !== 0) begin n_fail++; $display("FAIL dir_waits: got %0d expected 0", w); end
        xfer(0, 1'b1, 7'd0, 8'h5A, 8'h00, w);
        n_checks++;
        if (w !== 0) begin n_fail++; $display("FAIL dout_waits: got %0d expected 0", w); end
        n_checks++;
        if (gpio_oe[0] !== 8'hF0) begin n_fail++; $display("FAIL gpio_oe: got %h expected f0", gpio_oe[0]); end
        n_checks++;
        if (gpio_out[0] !== 8'h5A) begin n_fail++; $display("FAIL gpio_out: got %h expected 5a", gpio_out[0]); end
        xfer(0, 1'b0, 7'd1, 8'h00, 8'hF0, w);
        xfer(0, 1'b0, 7'd0, 8'h00, 8'h5A, w);
    endtask

    task automatic test_set_clr();
        int w;
        xfer(0, 1'b1, 7'd3, 8'h01, 8'h00, w);
        n_checks++;
        if (gpio_out[0] !== 8'h5B) begin n_fail++; $display("FAIL out_set: got %h expected 5b", gpio_out[0]); end
        xfer(0, 1'b1, 7'd4, 8'h50, 8'h00, w);
        n_checks++;
        if (gpio_out[0] !== 8'h0B) begin n_fail++; $display("FAIL out_clr: got %h expected 0b", gpio_out[0]); end
        xfer(0, 1'b0, 7'd3, 8'h00, 8'h00, w);
        xfer(0, 1'b0, 7'd4, 8'h00, 8'h00, w);
    endtask

    task automatic test_irq();
        int w;
        xfer(0, 1'b1, 7'd5, 8'h02, 8'h00, w);
        @(posedge sclk); #1;
        gpio_in[0] = 8'h03;
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        n_checks++;
        if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b expected 0", irq[0]); end
        @(posedge sclk);
        @(negedge sclk);
        n_checks++;
        if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b expected 1", irq[0]); end
        xfer(0, 1'b0, 7'd6, 8'h00, 8'h03, w);
        xfer(0, 1'b0, 7'd2, 8'h00, 8'h03, w);
        xfer(0, 1'b1, 7'd2, 8'hFF, 8'h00, w);
        xfer(0, 1'b0, 7'd2, 8'h00, 8'h03, w);
        xfer(0, 1'b1, 7'd6, 8'h02, 8'h00, w);
        n_checks++;
        if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b expected 0", irq[0]); end
        xfer(0, 1'b0, 7'd6, 8'h00, 8'h01, w);
    endtask

    task automatic test_wait_states();
        int w;
        xfer(1, 1'b0, 7'd7, 8'h00, 8'hA5, w);
        n_checks++;
        if (w !== 3) begin n_fail++; $display("FAIL ws_read_waits: got %0d expected 3", w); end
        xfer(1, 1'b1, 7'd0, 8'h3C, 8'h00, w);
        n_checks++;
        if (w !== 3) begin n_fail++; $display("FAIL ws_write_waits: got %0d expected 3", w); end
        n_checks++;
        if (gpio_out[1] !== 8'h3C) begin n_fail++; $display("FAIL ws_gpio_out: got %h expected 3c", gpio_out[1]); end
        xfer(0, 1'b0, 7'd7, 8'h00, 8'hA5, w);
        n_checks++;
        if (w !== 0) begin n_fail++; $display("FAIL id_waits0: got %0d expected 0", w); end
    endtask

    task automatic test_abort();
        int w;
        @(posedge sclk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 7'd0; pwdata[1] = 8'hC3;
        @(posedge sclk); #1;
        penable[1] = 1'b1;
        @(negedge sclk);
        n_checks++;
        if (pready[1] !== 1'b0) begin n_fail++; $display("FAIL abort_pready: got %b expected 0", pready[1]); end
        @(posedge sclk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        repeat (4) @(posedge sclk);
        @(negedge sclk);
        n_checks++;
        if (gpio_out[1] !== 8'h3C) begin n_fail++; $display("FAIL abort_out: got %h expected 3c", gpio_out[1]); end
        xfer(1, 1'b0, 7'd0, 8'h00, 8'h3C, w);
        n_checks++;
        if (w !== 3) begin n_fail++; $display("FAIL abort_recover_waits: got %0d expected 3", w); end
    endtask

    task automatic test_upper_addr();
        int w;
        xfer(0, 1'b1, 7'h09, 8'hFF, 8'h00, w);
        n_checks++;
        if (w !== 0) begin n_fail++; $display("FAIL upper_waits: got %0d expected 0", w); end
        n_checks++;
        if (gpio_oe[0] !== 8'hF0) begin n_fail++; $display("FAIL upper_oe: got %h expected f0", gpio_oe[0]); end
        xfer(0, 1'b0, 7'h09, 8'h00, 8'h00, w);
        xfer(0, 1'b0, 7'h0F, 8'h00, 8'h00, w);
        xfer(0, 1'b0, 7'd1, 8'h00, 8'hF0, w);
    endtask

    task automatic test_back_to_back();
        @(posedge sclk); #1;
        q0.push_back(8'hA5);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 7'd7;
        @(posedge sclk); #1;
        penable[0] = 1'b1;
        @(negedge sclk);
        n_checks++;
        if (pready[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %b expected 1", pready[0]); end
        @(posedge sclk); #1;
        q0.push_back(8'h0B);
        penable[0] = 1'b0; paddr[0] = 7'd0;
        @(negedge sclk);
        n_checks++;
        if (pready[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_setup: got %b expected 0", pready[0]); end
        @(posedge sclk); #1;
        penable[0] = 1'b1;
        @(negedge sclk);
        n_checks++;
        if (pready[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %b expected 1", pready[0]); end
        @(posedge sclk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int w;
        xfer(1, 1'b1, 7'd0, 8'h00, 8'h00, w);
        @(posedge sclk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 7'd0; pwdata[1] = 8'h99;
        @(posedge sclk); #1;
        penable[1] = 1'b1;
        @(negedge sclk); #2;
        resetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({pready[d], irq[d], prdata[d], gpio_out[d], gpio_oe[d]} !== 25'd0) begin
                n_fail++;
                $display("FAIL midreset_outputs%0d: got %h expected 0", d,
                         {pready[d], irq[d], prdata[d], gpio_out[d], gpio_oe[d]});
            end
        end
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge sclk); #1;
        resetn = 1'b1;
        xfer(1, 1'b0, 7'd0, 8'h00, 8'h00, w);
        n_checks++;
        if (gpio_out[1] !== 8'h00) begin n_fail++; $display("FAIL midreset_out: got %h expected 00", gpio_out[1]); end
    endtask

    initial begin
        test_reset();
        test_dir_data();
        test_set_clr();
        test_irq();
        test_wait_states();
        test_abort();
        test_upper_addr();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge sclk);
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL pending_reads: got %0d/%0d expected 0/0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
